instruction_fetch_queue: RTL and testbench

//   Fetch front end upstream of the LEGv8 datapath. Generates sequential PCs, issues word requests to a

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/instruction_fetch_queue.sv | 100 ++++++++++
 tb/tb_instruction_fetch_queue.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the queue entry type for the instruction fetch front end
package fetch_pkg;

    localparam int DEF_DEPTH   = 4;
    localparam int DEF_ADDR_W  = 64;
    localparam int DEF_INSTR_W = 32;
    localparam int PC_INCR     = 4;

    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: in-order DEPTH-entry queue of fetch entries with flush, no fall-through
module fetch_fifo import fetch_pkg::*; #(
    parameter int  DEPTH   = DEF_DEPTH,
    parameter type entry_t = fetch_entry_t,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic          CLK,
    input  logic          resetl,
    input  logic          flush,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    output entry_t        head,
    output logic [CW-1:0] count
);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    // qualify push/pop against flush and occupancy; empty queue presents zeros
    always_comb begin
        do_push = push && !flush && count != CW'(DEPTH);
        do_pop  = pop && !flush && count != '0;
        head    = count != '0 ? mem[rd_ptr] : entry_t'('0);
    end

    // pointer and occupancy bookkeeping; flush returns to the empty state
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // entry storage; contents are only observed through head when count is nonzero
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: sequential PC fetch with credit-limited memory requests and redirect flush
module instruction_fetch_queue import fetch_pkg::*; #(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               CLK,
    input  logic               resetl,
    input  logic [ADDR_W-1:0]  startpc,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
);

    localparam int                CW    = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] INCR  = ADDR_W'(PC_INCR);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     drop;
    logic [CW-1:0]     count;
    logic [CW:0]       credit_used;
    logic              req_fire;
    logic              rsp_take;
    logic              push;
    logic              pop;
    entry_t            push_entry;
    entry_t            head;

    // credit check counts buffered plus live in-flight words; dropped responses never occupy the queue
    always_comb begin
        credit_used    = {1'b0, count} + {1'b0, inflight} - {1'b0, drop};
        imem_req_valid = resetl && !redirect && credit_used < (CW+1)'(DEPTH);
        imem_req_addr  = fetch_pc;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_take       = imem_rsp_valid && inflight != '0;
        push           = rsp_take && drop == '0 && !redirect;
        out_valid      = count != '0;
        pop            = out_valid && out_ready && !redirect;
        push_entry     = '{instr: imem_rsp_data, pc: rsp_pc};
        out_instr      = head.instr;
        out_pc         = head.pc;
    end

    // fetch/response PCs, outstanding-request and discard counters
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            fetch_pc <= startpc & ALIGN;
            rsp_pc   <= startpc & ALIGN;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight + CW'(req_fire) - CW'(rsp_take);
            if (redirect) begin
                fetch_pc <= redirect_pc & ALIGN;
                rsp_pc   <= redirect_pc & ALIGN;
                drop     <= inflight - CW'(rsp_take);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + INCR;
                if (push) rsp_pc <= rsp_pc + INCR;
                if (rsp_take && drop != '0) drop <= drop - CW'(1);
            end
        end
    end

    // a response with nothing outstanding is a bus protocol violation
    always_ff @(posedge CLK) begin
        if (resetl) assert (!imem_rsp_valid || inflight != '0);
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .CLK       (CLK),
        .resetl    (resetl),
        .flush     (redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb_instruction_fetch_queue: directed checks of fetch order, credit limit, redirect drop and reset
module tb_instruction_fetch_queue;

    localparam int AW = 64;
    localparam int IW = 32;

    logic          CLK = 1'b0;
    logic          resetl;
    logic [AW-1:0] startpc;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [AW-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [IW-1:0] imem_rsp_data;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_instr;
    logic [AW-1:0] out_pc;

    int checks = 0;
    int errors = 0;
    int lat = 1;
    int cyc_cnt = 0;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } req_t;

    req_t          mq[$];
    logic [AW-1:0] req_log[$];
    logic [AW-1:0] pop_log[$];

    instruction_fetch_queue dut (
        .CLK            (CLK),
        .resetl         (resetl),
        .startpc        (startpc),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    always #5 CLK = ~CLK;

    function automatic logic [IW-1:0] word_at(input logic [AW-1:0] a);
        return a[31:0] ^ 32'hDEAD_BEEF;
    endfunction

    function automatic logic [AW-1:0] at(input logic [AW-1:0] q[$], input int i);
        return (i < q.size()) ? q[i] : '1;
    endfunction

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input logic [AW-1:0] pc, input int l);
        resetl = 1'b0;
        startpc = pc;
        lat = l;
        redirect = 1'b0;
        out_ready = 1'b1;
        cyc(2);
        req_log.delete();
        pop_log.delete();
        resetl = 1'b1;
    endtask

    // in-order memory with fixed latency, at most one response per cycle
    always @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            mq.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data <= '0;
        end else begin
            if (imem_req_valid && imem_req_ready) mq.push_back('{imem_req_addr, cyc_cnt + lat});
            if (mq.size() != 0 && mq[0].due <= cyc_cnt + 1) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data <= word_at(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
            cyc_cnt <= cyc_cnt + 1;
        end
    end

    // record accepted requests and consumed entries between edges
    always @(negedge CLK) begin
        if (resetl) begin
            if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
            if (out_valid && out_ready && !redirect) begin
                pop_log.push_back(out_pc);
                chk("instr_vs_pc", {32'b0, out_instr}, {32'b0, word_at(out_pc)});
            end
        end
    end

    initial begin
        resetl = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        startpc = 64'h1000;
        out_ready = 1'b1;
        imem_req_ready = 1'b1;
        #2 resetl = 1'b0;
        cyc(2);
        chk("rst_req_valid", {63'b0, imem_req_valid}, 64'd0);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_instr", {32'b0, out_instr}, 64'd0);
        chk("rst_req_addr", imem_req_addr, 64'h1000);
        resetl = 1'b1;

        cyc(10);
        chk("t1_req0", at(req_log, 0), 64'h1000);
        chk("t1_req1", at(req_log, 1), 64'h1004);
        chk("t1_req2", at(req_log, 2), 64'h1008);
        chk("t1_pop0", at(pop_log, 0), 64'h1000);
        chk("t1_pop1", at(pop_log, 1), 64'h1004);
        chk("t1_pop2", at(pop_log, 2), 64'h1008);

        do_reset(64'h1000, 1);
        out_ready = 1'b0;
        cyc(10);
        chk("t2_nreq", 64'(req_log.size()), 64'd4);
        chk("t2_req_valid", {63'b0, imem_req_valid}, 64'd0);
        chk("t2_out_valid", {63'b0, out_valid}, 64'd1);
        chk("t2_head_pc", out_pc, 64'h1000);
        chk("t2_npop", 64'(pop_log.size()), 64'd0);
        out_ready = 1'b1;
        cyc(10);
        chk("t2_pop0", at(pop_log, 0), 64'h1000);
        chk("t2_pop3", at(pop_log, 3), 64'h100C);
        chk("t2_pop4", at(pop_log, 4), 64'h1010);
        chk("t2_req4", at(req_log, 4), 64'h1010);

        do_reset(64'h1000, 4);
        cyc(3);
        redirect = 1'b1;
        redirect_pc = 64'h2000;
        #1;
        chk("t3_req_blocked", {63'b0, imem_req_valid}, 64'd0);
        cyc(1);
        redirect = 1'b0;
        cyc(20);
        chk("t3_req2", at(req_log, 2), 64'h1008);
        chk("t3_req3", at(req_log, 3), 64'h2000);
        chk("t3_pop0", at(pop_log, 0), 64'h2000);
        chk("t3_pop1", at(pop_log, 1), 64'h2004);
        chk("t3_pop2", at(pop_log, 2), 64'h2008);
        chk("t3_pop3", at(pop_log, 3), 64'h200C);

        do_reset(64'h1000, 2);
        cyc(3);
        chk("t4_pre_valid", {63'b0, out_valid}, 64'd1);
        chk("t4_pre_pc", out_pc, 64'h1000);
        redirect = 1'b1;
        redirect_pc = 64'h2000;
        cyc(1);
        redirect = 1'b0;
        chk("t4_flush_valid", {63'b0, out_valid}, 64'd0);
        cyc(1);
        chk("t4_drop_valid", {63'b0, out_valid}, 64'd0);
        cyc(15);
        chk("t4_req3", at(req_log, 3), 64'h2000);
        chk("t4_pop0", at(pop_log, 0), 64'h2000);
        chk("t4_pop1", at(pop_log, 1), 64'h2004);
        chk("t4_pop2", at(pop_log, 2), 64'h2008);

        do_reset(64'hFFFF_FFFF_FFFF_FFF8, 1);
        cyc(8);
        chk("t5_nreq", 64'(req_log.size() >= 4), 64'd1);
        chk("t5_req0", at(req_log, 0), 64'hFFFF_FFFF_FFFF_FFF8);
        chk("t5_req1", at(req_log, 1), 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_req2", at(req_log, 2), 64'h0);
        chk("t5_req3", at(req_log, 3), 64'h4);
        chk("t5_pop2", at(pop_log, 2), 64'h0);
        redirect = 1'b1;
        redirect_pc = 64'h3003;
        req_log.delete();
        pop_log.delete();
        cyc(1);
        redirect = 1'b0;
        chk("t5_align_addr", imem_req_addr, 64'h3000);
        cyc(10);
        chk("t5_req_r0", at(req_log, 0), 64'h3000);
        chk("t5_req_r1", at(req_log, 1), 64'h3004);
        chk("t5_pop_r0", at(pop_log, 0), 64'h3000);

        do_reset(64'h1000, 1);
        cyc(6);
        chk("t6_busy", {63'b0, out_valid}, 64'd1);
        #2;
        startpc = 64'h5000;
        resetl = 1'b0;
        #1;
        chk("t6_req_valid", {63'b0, imem_req_valid}, 64'd0);
        chk("t6_out_valid", {63'b0, out_valid}, 64'd0);
        chk("t6_out_pc", out_pc, 64'd0);
        chk("t6_out_instr", {32'b0, out_instr}, 64'd0);
        chk("t6_req_addr", imem_req_addr, 64'h5000);
        cyc(2);
        req_log.delete();
        pop_log.delete();
        resetl = 1'b1;
        cyc(10);
        chk("t6_req0", at(req_log, 0), 64'h5000);
        chk("t6_req3", at(req_log, 3), 64'h500C);
        chk("t6_pop0", at(pop_log, 0), 64'h5000);
        chk("t6_pop1", at(pop_log, 1), 64'h5004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
